// File: rtl/fetch_issue_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order tag FIFO,
// response buffer presented to decode with valid/ready, redirect and HALT handling.
module fetch_issue_unit #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = 16'h0000,
  parameter int                MAX_OUTST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [15:0]       imem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [15:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc_plus2,
  output logic              halted
);

  localparam int                PW         = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int                CW         = $clog2(MAX_OUTST + 1);
  localparam logic [CW:0]       MAX_CREDIT = (CW+1)'(MAX_OUTST);
  localparam logic [15:0]       NOP_INSTR  = 16'h0800;
  localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(2);

  typedef enum logic {RUN, HALT} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CW-1:0]     outst_reg, outst_next;
  logic [CW-1:0]     drop_reg, drop_next;
  logic [CW-1:0]     buf_count_reg, buf_count_next;
  logic [PW-1:0]     buf_wr_reg, buf_wr_next, buf_rd_reg, buf_rd_next;
  logic [PW-1:0]     tag_wr_reg, tag_wr_next, tag_rd_reg, tag_rd_next;

  logic [15:0]       buf_instr_mem [MAX_OUTST];
  logic [ADDR_W-1:0] buf_pc2_mem   [MAX_OUTST];
  logic [ADDR_W-1:0] tag_mem       [MAX_OUTST];

  logic credit_ok, issue, resp, halt_accept, flush, push, pop;

  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign credit_ok = ({1'b0, outst_reg} + {1'b0, buf_count_reg}) < MAX_CREDIT;
  assign imem_req  = rst_n && (state_reg == RUN) && !redirect && credit_ok;
  assign imem_addr = fetch_pc_reg;

  assign dec_valid    = (state_reg == RUN) && (buf_count_reg != '0);
  assign dec_instr    = dec_valid ? buf_instr_mem[buf_rd_reg] : NOP_INSTR;
  assign dec_pc_plus2 = dec_valid ? buf_pc2_mem[buf_rd_reg] : '0;
  assign halted       = (state_reg == HALT);

  assign issue       = imem_req && imem_gnt;
  assign resp        = imem_rvalid && (outst_reg != '0);
  assign halt_accept = dec_valid && dec_ready && (dec_instr[15:11] == 5'b00000);
  assign flush       = redirect || halt_accept;
  assign push        = resp && (drop_reg == '0) && !flush;
  assign pop         = dec_valid && dec_ready && !flush;

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    outst_next     = outst_reg + CW'(issue) - CW'(resp);
    drop_next      = drop_reg;
    buf_count_next = buf_count_reg + CW'(push) - CW'(pop);
    buf_wr_next    = buf_wr_reg + PW'(push);
    buf_rd_next    = buf_rd_reg + PW'(pop);
    tag_wr_next    = tag_wr_reg + PW'(issue);
    tag_rd_next    = tag_rd_reg + PW'(push);

    if (resp && (drop_reg != '0))
      drop_next = drop_reg - CW'(1);
    if (issue)
      fetch_pc_next = fetch_pc_reg + PC_STEP;

    // Every request still in flight after this cycle becomes stale.
    if (flush) begin
      drop_next      = outst_next;
      buf_count_next = '0;
      buf_wr_next    = '0;
      buf_rd_next    = '0;
      tag_wr_next    = '0;
      tag_rd_next    = '0;
    end

    if (redirect) begin
      state_next    = RUN;
      fetch_pc_next = redirect_pc;
    end else if (halt_accept) begin
      state_next = HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      fetch_pc_reg  <= RESET_PC;
      outst_reg     <= '0;
      drop_reg      <= '0;
      buf_count_reg <= '0;
      buf_wr_reg    <= '0;
      buf_rd_reg    <= '0;
      tag_wr_reg    <= '0;
      tag_rd_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      outst_reg     <= outst_next;
      drop_reg      <= drop_next;
      buf_count_reg <= buf_count_next;
      buf_wr_reg    <= buf_wr_next;
      buf_rd_reg    <= buf_rd_next;
      tag_wr_reg    <= tag_wr_next;
      tag_rd_reg    <= tag_rd_next;
    end
  end

  // Storage needs no reset: contents are only observed through valid counts.
  always_ff @(posedge clk) begin
    if (issue)
      tag_mem[tag_wr_reg] <= fetch_pc_reg + PC_STEP;
    if (push) begin
      buf_instr_mem[buf_wr_reg] <= imem_rdata;
      buf_pc2_mem[buf_wr_reg]   <= tag_mem[tag_rd_reg];
    end
  end

endmodule

// File: tb/tb_fetch_issue_unit.sv
// Directed and randomized bench for fetch_issue_unit against a program-order
// reference model plus an in-order instruction memory model.
module tb_fetch_issue_unit;

  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [15:0] dec_instr;
  logic [15:0] dec_pc_plus2;
  logic        halted;

  always #5 clk = ~clk;

  fetch_issue_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc_plus2(dec_pc_plus2), .halted(halted)
  );

  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;

  logic [15:0] imem_arr [0:32767];
  mreq_t       mq[$];
  int          cyc = 0, last_due = 0, checks = 0, errors = 0;

  bit          rst_req = 0, tb_ready = 0, tb_redirect = 0, rand_mode = 0;
  bit          mode_two = 0, mode_pop = 0, mode_halt = 0;
  int          lat_extra = 0;
  logic [15:0] tb_rpc = 16'h0;

  // Reference: next instruction decode should see, next address to be fetched, halt status.
  logic [15:0] m_pc, m_issue;
  bit          m_halted;
  logic [15:0] iss_log[$], dlv_log[$];
  int          iss_cnt = 0, dlv_cnt = 0, first_iss_cyc = -1, first_val_cyc = -1;

  logic        s_req, s_valid, s_halted;
  logic [15:0] s_addr, s_instr, s_pc2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_issue = 16'h0000; m_halted = 0;
    mq.delete(); last_due = 0;
    iss_log.delete(); dlv_log.delete();
    first_iss_cyc = -1; first_val_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},   32'(imem_req), 0);
    chk({tag, "_valid"}, 32'(dec_valid), 0);
    chk({tag, "_instr"}, 32'(dec_instr), 32'h0800);
    chk({tag, "_pc2"},   32'(dec_pc_plus2), 0);
    chk({tag, "_halt"},  32'(halted), 0);
  endtask

  task automatic cycle();
    bit iss;
    int due;
    @(negedge clk);
    rst_n = rst_req;
    if (rand_mode) begin
      imem_gnt    = ($urandom_range(0, 3) != 0);
      lat_extra   = $urandom_range(0, 3);
      dec_ready   = ($urandom_range(0, 3) != 0);
      tb_redirect = ($urandom_range(0, 99) < (m_halted ? 20 : 3));
      tb_rpc      = 16'($urandom) & 16'hFFFE;
    end else begin
      imem_gnt  = 1'b1;
      dec_ready = tb_ready;
    end
    if (!rst_n) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem_arr[mq[0].addr[15:1]];
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'($urandom);
    end
    redirect    = tb_redirect;
    redirect_pc = tb_rpc;
    if (mode_two && mq.size() == 2) begin redirect = 1'b1; mode_two = 0; end
    if (mode_pop && imem_rvalid && dec_valid && dec_ready) begin redirect = 1'b1; mode_pop = 0; end
    if (mode_halt && dec_valid && dec_ready && dec_instr[15:11] == 5'b00000) begin
      redirect = 1'b1; mode_halt = 0;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = dec_valid;
    s_instr = dec_instr; s_pc2 = dec_pc_plus2; s_halted = halted;
    if (!rst_n) begin
      check_reset_outputs("rst");
      model_reset();
    end else begin
      chk("halted", 32'(s_halted), 32'(m_halted));
      if (m_halted) begin
        chk("halt_noreq", 32'(s_req), 0);
        chk("halt_novalid", 32'(s_valid), 0);
      end
      if (redirect) chk("redir_noreq", 32'(s_req), 0);
      if (s_valid) begin
        chk("head_instr", 32'(s_instr), 32'(imem_arr[m_pc[15:1]]));
        chk("head_pc2", 32'(s_pc2), 32'(16'(m_pc + 16'd2)));
        if (first_val_cyc < 0) first_val_cyc = cyc;
      end
      iss = s_req && imem_gnt;
      if (iss) begin
        chk("iss_addr", 32'(s_addr), 32'(m_issue));
        chk("iss_credit", 32'(mq.size() < MAX_OUTST), 1);
        iss_log.push_back(s_addr);
        iss_cnt++;
        m_issue = m_issue + 16'd2;
        if (first_iss_cyc < 0) first_iss_cyc = cyc;
      end
      if (imem_rvalid) void'(mq.pop_front());
      if (iss) begin
        due = (cyc + 1 + lat_extra > last_due + 1) ? cyc + 1 + lat_extra : last_due + 1;
        last_due = due;
        mq.push_back('{addr: s_addr, due: due});
      end
      if (redirect) begin
        m_pc = redirect_pc; m_issue = redirect_pc; m_halted = 0;
        iss_log.delete(); dlv_log.delete();
      end else if (s_valid && dec_ready) begin
        dlv_log.push_back(s_pc2);
        dlv_cnt++;
        if (imem_arr[m_pc[15:1]][15:11] == 5'b00000) m_halted = 1;
        m_pc = m_pc + 16'd2;
      end
    end
    cyc++;
  endtask

  function automatic logic [31:0] qget(input logic [15:0] q[$], input int idx);
    return (q.size() > idx) ? 32'(q[idx]) : 32'hFFFF_FFFF;
  endfunction

  task automatic do_redirect(input logic [15:0] pc);
    tb_rpc = pc; tb_redirect = 1; cycle(); tb_redirect = 0;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 32768; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 15) == 0) w[15:11] = 5'b00000;
      else if (w[15:11] == 5'b00000) w[15:11] = 5'b00001;
      if (i < 64 && w[15:11] == 5'b00000) w[15:11] = 5'b00100;
      imem_arr[i] = w;
    end
    imem_arr[0] = 16'h2001; imem_arr[1] = 16'h2002; imem_arr[2] = 16'h2003;
    imem_arr[3] = 16'h0000; imem_arr[32767] = 16'h2005;
    model_reset();

    // Reset state
    rst_req = 0; tb_ready = 1;
    repeat (3) cycle();

    // Straight line from reset into HALT at PC 6
    rst_req = 1;
    for (int i = 0; i < 40 && !m_halted; i++) cycle();
    chk("sl_halt_seen", 32'(m_halted), 1);
    chk("sl_addr0", qget(iss_log, 0), 32'h0000);
    chk("sl_addr1", qget(iss_log, 1), 32'h0002);
    chk("sl_addr2", qget(iss_log, 2), 32'h0004);
    chk("sl_pc2_0", qget(dlv_log, 0), 32'h0002);
    chk("sl_pc2_1", qget(dlv_log, 1), 32'h0004);
    chk("sl_pc2_2", qget(dlv_log, 2), 32'h0006);
    chk("sl_latency", 32'(first_val_cyc - first_iss_cyc), 2);
    cycle();
    chk("halt_out", 32'(s_halted), 1);
    iss_cnt = 0;
    repeat (5) cycle();
    chk("halt_no_issue", 32'(iss_cnt), 0);

    // Resume at 0x10, then decode backpressure
    do_redirect(16'h0010);
    tb_ready = 0; iss_cnt = 0;
    repeat (6) cycle();
    chk("bp_issues", 32'(iss_cnt), 2);
    chk("bp_req_low", 32'(s_req), 0);
    chk("bp_first_addr", qget(iss_log, 0), 32'h0010);
    tb_ready = 1;
    repeat (10) cycle();
    chk("bp_first_pc2", qget(dlv_log, 0), 32'h0012);
    chk("bp_progress", 32'(dlv_log.size() >= 4), 1);

    // Redirect with two requests in flight
    lat_extra = 3; mode_two = 1; tb_rpc = 16'h0040;
    for (int i = 0; i < 20 && mode_two; i++) cycle();
    chk("two_outst_hit", 32'(mode_two), 0);
    repeat (15) cycle();
    chk("two_next_addr", qget(iss_log, 0), 32'h0040);
    chk("two_first_pc2", qget(dlv_log, 0), 32'h0042);
    lat_extra = 0;

    // Redirect together with a response and a pop
    mode_pop = 1; tb_rpc = 16'h0050;
    for (int i = 0; i < 20 && mode_pop; i++) cycle();
    chk("sim1_hit", 32'(mode_pop), 0);
    cycle();
    chk("sim1_empty", 32'(s_valid), 0);
    repeat (8) cycle();
    chk("sim1_first_pc2", qget(dlv_log, 0), 32'h0052);

    // Redirect together with accepting a HALT
    do_redirect(16'h0004);
    mode_halt = 1; tb_rpc = 16'h0020;
    for (int i = 0; i < 20 && mode_halt; i++) cycle();
    chk("sim2_hit", 32'(mode_halt), 0);
    cycle();
    chk("sim2_running", 32'(s_halted), 0);
    repeat (8) cycle();
    chk("sim2_first_pc2", qget(dlv_log, 0), 32'h0022);

    // Address wrap
    do_redirect(16'hFFFE);
    repeat (6) cycle();
    chk("wrap_addr0", qget(iss_log, 0), 32'hFFFE);
    chk("wrap_addr1", qget(iss_log, 1), 32'h0000);
    chk("wrap_pc2", qget(dlv_log, 0), 32'h0000);

    // Asynchronous reset mid-burst
    lat_extra = 1;
    do_redirect(16'h0030);
    repeat (3) cycle();
    @(posedge clk);
    #2;
    rst_n = 0; rst_req = 0;
    #1;
    check_reset_outputs("async");
    repeat (2) cycle();
    rst_req = 1; lat_extra = 0;
    repeat (8) cycle();
    chk("post_rst_addr", qget(iss_log, 0), 32'h0000);

    // Randomized traffic
    rand_mode = 1; dlv_cnt = 0;
    repeat (3000) cycle();
    rand_mode = 0; tb_redirect = 0;
    chk("rand_progress", 32'(dlv_cnt > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
